nn_window_sched: RTL and testbench

- Sequences the NN classifier over one captured 28-line band of the ping-pong line buffer.
- On each band-ready pulse, walks NUM_WIN horizontally adjacent WIN x WIN windows.
- Per window: issues buffer read addresses pixel by pixel, drives the NN input-valid, waits for the NN result, then tags that result with window and band coordinates.
- Sits between the line-capture writer (bank handshake) and the nn core.

---
 rtl/nn_window_sched.sv | 151 +++++++++++++++
 tb/tb_nn_window_sched.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_window_sched.sv
// Window scheduler for the NN classifier: walks NUM_WIN WIN x WIN windows across one
// captured line-buffer band, streams pixel addresses to the buffer and tags each NN result.
module nn_window_sched #(
  parameter int LN_SIZE  = 640,
  parameter int WIN      = 28,
  parameter int NUM_WIN  = 22,
  parameter int NUM_BAND = 17,
  parameter int AW       = 15
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          band_ready,
  input  logic          band_bank,
  input  logic          frame_start,
  output logic [AW-1:0] rd_addr,
  output logic          rd_bank,
  output logic          x_valid,
  input  logic          y_valid,
  output logic          res_valid,
  output logic [4:0]    res_win,
  output logic [4:0]    res_band,
  output logic          busy,
  output logic          bank_release,
  output logic          frame_done,
  output logic          overrun
);

  localparam int CW = (WIN > 1) ? $clog2(WIN) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_Y, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] row, col;
  logic [4:0]    win_idx, band_idx;
  logic          fs_pend;
  logic          vld_p0;
  logic          last_pix, last_win, last_band;

  function automatic logic [AW-1:0] pix_addr(input logic [CW-1:0] r,
                                             input logic [CW-1:0] c,
                                             input logic [4:0]    w);
    return AW'(c) * AW'(LN_SIZE) + AW'(w) * AW'(WIN) + AW'(r);
  endfunction

  assign last_pix  = (row == CW'(WIN - 1)) && (col == CW'(WIN - 1));
  assign last_win  = (win_idx == 5'(NUM_WIN - 1));
  assign last_band = (band_idx == 5'(NUM_BAND - 1));

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (band_ready) state_nxt = ISSUE;
      ISSUE:   if (last_pix) state_nxt = WAIT_Y;
      WAIT_Y:  if (y_valid) state_nxt = last_win ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      row          <= '0;
      col          <= '0;
      win_idx      <= '0;
      band_idx     <= '0;
      fs_pend      <= 1'b0;
      vld_p0       <= 1'b0;
      rd_addr      <= '0;
      rd_bank      <= 1'b0;
      x_valid      <= 1'b0;
      res_valid    <= 1'b0;
      res_win      <= '0;
      res_band     <= '0;
      busy         <= 1'b0;
      bank_release <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      // p0: address registered; p1: RAM data valid, strobed into the NN as x_valid
      vld_p0       <= 1'b0;
      x_valid      <= vld_p0;
      res_valid    <= 1'b0;
      bank_release <= 1'b0;
      frame_done   <= 1'b0;

      if (frame_start) overrun <= 1'b0;
      if (band_ready && state != IDLE) overrun <= 1'b1;
      // A frame start during a band only takes effect on band_idx once the band retires
      if (frame_start && state != IDLE) fs_pend <= 1'b1;

      unique case (state)
        IDLE: begin
          if (frame_start) begin
            band_idx <= '0;
            fs_pend  <= 1'b0;
          end
          if (band_ready) begin
            rd_bank <= band_bank;
            busy    <= 1'b1;
            win_idx <= '0;
            row     <= '0;
            col     <= '0;
          end
        end
        ISSUE: begin
          rd_addr <= pix_addr(row, col, win_idx);
          vld_p0  <= 1'b1;
          if (last_pix) begin
            row <= '0;
            col <= '0;
          end else if (row == CW'(WIN - 1)) begin
            row <= '0;
            col <= col + CW'(1);
          end else begin
            row <= row + CW'(1);
          end
        end
        WAIT_Y: begin
          if (y_valid) begin
            res_valid <= 1'b1;
            res_win   <= win_idx;
            res_band  <= band_idx;
            row       <= '0;
            col       <= '0;
            if (!last_win) win_idx <= win_idx + 5'd1;
          end
        end
        DONE: begin
          bank_release <= 1'b1;
          busy         <= 1'b0;
          fs_pend      <= 1'b0;
          if (fs_pend || frame_start) begin
            band_idx <= '0;
          end else if (last_band) begin
            frame_done <= 1'b1;
            band_idx   <= '0;
          end else begin
            band_idx <= band_idx + 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nn_window_sched.sv
// Bench for nn_window_sched: a full-size instance for address/sequencing checks and a
// reduced-size instance so whole frames fit in a short run.
module tb_nn_window_sched;

  localparam int S_LN = 12, S_WIN = 3, S_NWIN = 4, S_NBAND = 17, S_AW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic band_ready = 1'b0, band_bank = 1'b0, frame_start = 1'b0, y_valid = 1'b0;
  logic sel = 1'b0;
  int   checks = 0, errors = 0;
  int   band_m [2];

  logic [14:0]     d_rd_addr;
  logic [S_AW-1:0] s_rd_addr;
  logic [4:0]      d_res_win, d_res_band, s_res_win, s_res_band;
  logic d_rd_bank, d_x_valid, d_res_valid, d_busy, d_bank_release, d_frame_done, d_overrun;
  logic s_rd_bank, s_x_valid, s_res_valid, s_busy, s_bank_release, s_frame_done, s_overrun;

  logic [14:0] rd_addr;
  logic [4:0]  res_win, res_band;
  logic rd_bank, x_valid, res_valid, busy, bank_release, frame_done, overrun;

  always #5 clk = ~clk;

  nn_window_sched dut (
    .Clk(clk), .Rst(rst), .band_ready(band_ready & ~sel), .band_bank(band_bank),
    .frame_start(frame_start & ~sel), .rd_addr(d_rd_addr), .rd_bank(d_rd_bank),
    .x_valid(d_x_valid), .y_valid(y_valid & ~sel), .res_valid(d_res_valid),
    .res_win(d_res_win), .res_band(d_res_band), .busy(d_busy),
    .bank_release(d_bank_release), .frame_done(d_frame_done), .overrun(d_overrun)
  );

  nn_window_sched #(.LN_SIZE(S_LN), .WIN(S_WIN), .NUM_WIN(S_NWIN), .NUM_BAND(S_NBAND), .AW(S_AW)) dut_s (
    .Clk(clk), .Rst(rst), .band_ready(band_ready & sel), .band_bank(band_bank),
    .frame_start(frame_start & sel), .rd_addr(s_rd_addr), .rd_bank(s_rd_bank),
    .x_valid(s_x_valid), .y_valid(y_valid & sel), .res_valid(s_res_valid),
    .res_win(s_res_win), .res_band(s_res_band), .busy(s_busy),
    .bank_release(s_bank_release), .frame_done(s_frame_done), .overrun(s_overrun)
  );

  assign rd_addr      = sel ? {9'd0, s_rd_addr} : d_rd_addr;
  assign rd_bank      = sel ? s_rd_bank      : d_rd_bank;
  assign x_valid      = sel ? s_x_valid      : d_x_valid;
  assign res_valid    = sel ? s_res_valid    : d_res_valid;
  assign res_win      = sel ? s_res_win      : d_res_win;
  assign res_band     = sel ? s_res_band     : d_res_band;
  assign busy         = sel ? s_busy         : d_busy;
  assign bank_release = sel ? s_bank_release : d_bank_release;
  assign frame_done   = sel ? s_frame_done   : d_frame_done;
  assign overrun      = sel ? s_overrun      : d_overrun;

  // Drives one band through the selected instance, acting as the NN core, and checks every
  // window against the address/tagging rules. Negative window arguments disable an injection.
  task automatic run_band(input logic bank, input int lat0, input int ovr_win,
                          input int fs_win, input int abort_win);
    int ln, win, nwin, nband, npix, nx, guard, bad_addr, gaps, spur, lat, exp_band, exp_a;
    int bad_act, bad_exp;
    logic [14:0] prev_addr;
    bit started, fs_seen, ovr_chk, exp_fd;
    ln    = sel ? S_LN : 640;
    win   = sel ? S_WIN : 28;
    nwin  = sel ? S_NWIN : 22;
    nband = sel ? S_NBAND : 17;
    npix  = win * win;
    fs_seen = 0;
    ovr_chk = 0;
    exp_band = band_m[sel];

    band_bank = bank;
    band_ready = 1'b1;
    @(negedge clk);
    band_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || rd_bank !== bank) begin
      errors++;
      $display("FAIL accept: busy=%b rd_bank=%b, required busy=1 rd_bank=%b", busy, rd_bank, bank);
    end

    for (int w = 0; w < nwin; w++) begin
      nx = 0; guard = 0; bad_addr = 0; gaps = 0; spur = 0; started = 0;
      bad_act = 0; bad_exp = 0;
      while (nx < npix && guard < 4 * npix + 20) begin
        prev_addr = rd_addr;
        @(negedge clk);
        guard++;
        band_ready = 1'b0;
        y_valid = 1'b0;
        frame_start = 1'b0;
        if (ovr_chk) begin
          ovr_chk = 0;
          checks++;
          if (overrun !== 1'b1 || rd_bank !== bank) begin
            errors++;
            $display("FAIL overrun_set: overrun=%b rd_bank=%b, required 1 and %b", overrun, rd_bank, bank);
          end
        end
        if (res_valid || bank_release || frame_done) spur++;
        if (x_valid) begin
          started = 1;
          exp_a = (nx / win) * ln + w * win + (nx % win);
          if (prev_addr !== 15'(exp_a)) begin
            if (bad_addr == 0) begin
              bad_act = int'(prev_addr);
              bad_exp = exp_a;
            end
            bad_addr++;
          end
          nx++;
          if (w == ovr_win && nx == npix / 2) begin
            band_bank = ~bank;
            band_ready = 1'b1;
            ovr_chk = 1;
          end
          if (w == fs_win && nx == 3) begin
            frame_start = 1'b1;
            fs_seen = 1;
          end
          if (nx == 5 && $urandom_range(1, 0) == 1) y_valid = 1'b1;
          if (w == abort_win && nx == npix / 2) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            y_valid = 1'b0;
            frame_start = 1'b0;
            checks++;
            if ({rd_addr, rd_bank, x_valid, res_valid, res_win, res_band, busy,
                 bank_release, frame_done, overrun} !== 32'd0) begin
              errors++;
              $display("FAIL abort_outputs: addr=%0d busy=%b xv=%b rv=%b rel=%b, required all 0",
                       rd_addr, busy, x_valid, res_valid, bank_release);
            end
            spur = 0;
            repeat (20) begin
              @(negedge clk);
              if (res_valid || bank_release || frame_done || busy || x_valid) spur++;
            end
            checks++;
            if (spur != 0) begin
              errors++;
              $display("FAIL abort_quiet: %0d active cycles after reset, required 0", spur);
            end
            band_m[0] = 0;
            band_m[1] = 0;
            return;
          end
        end else if (started && nx < npix) begin
          gaps++;
        end
      end

      checks++;
      if (nx != npix) begin
        errors++;
        $display("FAIL window_timeout w=%0d: %0d x_valid pulses, required %0d", w, nx, npix);
        return;
      end
      checks++;
      if (bad_addr != 0) begin
        errors++;
        $display("FAIL addr_seq w=%0d: %0d wrong, first got %0d required %0d", w, bad_addr, bad_act, bad_exp);
      end
      checks++;
      if (gaps != 0 || spur != 0) begin
        errors++;
        $display("FAIL issue_clean w=%0d: gaps=%0d stray pulses=%0d, required 0 and 0", w, gaps, spur);
      end

      @(negedge clk);
      band_ready = 1'b0;
      y_valid = 1'b0;
      frame_start = 1'b0;
      checks++;
      if (x_valid !== 1'b0) begin
        errors++;
        $display("FAIL xv_end w=%0d: x_valid=%b after last pixel, required 0", w, x_valid);
      end
      lat = (w == 0) ? lat0 : int'($urandom_range(12, 1));
      spur = 0;
      repeat (lat - 1) begin
        @(negedge clk);
        if (res_valid || x_valid) spur++;
      end
      y_valid = 1'b1;
      @(negedge clk);
      y_valid = 1'b0;
      checks++;
      if (spur != 0 || res_valid !== 1'b1 || res_win !== 5'(w) || res_band !== 5'(exp_band) || busy !== 1'b1) begin
        errors++;
        $display("FAIL result w=%0d: rv=%b win=%0d band=%0d busy=%b early=%0d, required 1 %0d %0d 1 0",
                 w, res_valid, res_win, res_band, busy, spur, w, exp_band);
      end
      @(negedge clk);
      if (w < nwin - 1) begin
        checks++;
        if (res_valid !== 1'b0 || bank_release !== 1'b0 || x_valid !== 1'b0) begin
          errors++;
          $display("FAIL between w=%0d: rv=%b rel=%b xv=%b, required 0 0 0", w, res_valid, bank_release, x_valid);
        end
      end
    end

    exp_fd = !fs_seen && (exp_band == nband - 1);
    checks++;
    if (bank_release !== 1'b1 || busy !== 1'b0 || frame_done !== exp_fd || res_valid !== 1'b0) begin
      errors++;
      $display("FAIL release band=%0d: rel=%b busy=%b fd=%b rv=%b, required 1 0 %b 0",
               exp_band, bank_release, busy, frame_done, res_valid, exp_fd);
    end
    @(negedge clk);
    checks++;
    if (bank_release !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0 || rd_bank !== bank) begin
      errors++;
      $display("FAIL after_release: rel=%b fd=%b busy=%b rd_bank=%b, required 0 0 0 %b",
               bank_release, frame_done, busy, rd_bank, bank);
    end
    band_m[sel] = (fs_seen || exp_band == nband - 1) ? 0 : exp_band + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    band_m[0] = 0;
    band_m[1] = 0;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      checks++;
      if ({rd_addr, rd_bank, x_valid, res_valid, res_win, res_band, busy,
           bank_release, frame_done, overrun} !== 32'd0) begin
        errors++;
        $display("FAIL reset_state inst=%0d: addr=%0d busy=%b xv=%b ovr=%b, required all 0",
                 s, rd_addr, busy, x_valid, overrun);
      end
    end
    sel = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_first_band();
    sel = 1'b0;
    run_band(1'b1, 40, -1, -1, -1);
  endtask

  task automatic test_overrun();
    sel = 1'b0;
    run_band(1'b0, 5, 3, -1, -1);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: overrun=%b, required 1", overrun);
    end
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    band_m[0] = 0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear: overrun=%b, required 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    sel = 1'b0;
    run_band(1'b1, 5, -1, -1, 5);
    run_band(1'b0, 3, -1, -1, 1);
  endtask

  task automatic test_frame();
    sel = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    band_m[0] = 0;
    band_m[1] = 0;
    for (int b = 0; b < S_NBAND + 1; b++)
      run_band(1'($urandom_range(1, 0)), int'($urandom_range(12, 1)), -1, -1, -1);
  endtask

  task automatic test_frame_start_busy();
    sel = 1'b1;
    run_band(1'b1, 4, -1, -1, -1);
    run_band(1'b0, 4, 0, 2, -1);
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_busy_clear: overrun=%b, required 0", overrun);
    end
    run_band(1'b1, 2, -1, -1, -1);
  endtask

  initial begin
    test_reset();
    test_first_band();
    test_overrun();
    test_reset_mid();
    test_frame();
    test_frame_start_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
